grid_access_arbiter: RTL and testbench
======================================

Name: grid_access_arbiter

Overview:
- Shares the single-port grid RAM (memoryRAM, 1-cycle registered read) among NREQ placement engines.
- Arbitration is round-robin. Access types: read, write, and atomic claim (test-and-set). A claim writes a cell only if the cell holds EMPTY.
- Sits between the placement FSMs and the grid RAM. It removes read-then-write races when several engines place nodes in parallel.

Parameters:
- NREQ, 4, number of requesting engines.
- ADDR_W, 32, address width (signed, matches grid RAM).
- DATA_W, 32, data width.
- GRID_CELLS, 25, legal cell count (n*n). Addresses >= GRID_CELLS or < 0 are illegal.
- EMPTY, 32'hFFFFFFFF, free-cell marker (-1).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- req  in  NREQ  per-engine request.
- op  in  2*NREQ  per-engine opcode: 00 read, 01 write, 10 claim, 11 illegal.
- addr  in  NREQ*ADDR_W  per-engine cell address.
- wdata  in  NREQ*DATA_W  per-engine write/claim data.
- gnt  out  NREQ  one-cycle grant pulse, one-hot.
- done  out  NREQ  one-cycle completion pulse, one-hot.
- rdata  out  DATA_W  cell value read. Valid with done; held until the next completion.
- claim_ok  out  1  claim succeeded. Valid with done.
- err  out  1  illegal opcode or address. Valid with done.
- busy  out  1  high whenever state != IDLE.
- mem_re  out  1  grid RAM read.
- mem_we  out  1  grid RAM write.
- mem_addr  out  ADDR_W  grid RAM address.
- mem_din  out  DATA_W  grid RAM write data.
- mem_dout  in  DATA_W  grid RAM read data. Valid the cycle after mem_re.

Behaviour:
- Reset (reset=0, async): all outputs 0, rdata 0, state IDLE, RR pointer 0. Reset mid-operation drops mem_we/mem_re immediately; no done is issued and the interrupted request is lost.
- All outputs are registered.
- States: IDLE, ACCESS, CAPTURE, CLAIM_WR, FINISH.
- IDLE:
  - If any req is set, pick the winner: first set bit at or after the pointer, wrapping modulo NREQ.
  - Pulse gnt[w], latch op/addr/wdata[w], and set pointer = (w+1) mod NREQ.
  - Illegal op or address: next state FINISH with err=1 and no memory access.
  - Legal request: next state ACCESS. Drive mem_addr, with mem_re=1 (read/claim) or mem_we=1 and mem_din=wdata (write).
- ACCESS:
  - Write: the write is complete; go to FINISH.
  - Read/claim: go to CAPTURE.
  - mem_re/mem_we deasserted.
- CAPTURE:
  - Register mem_dout into rdata.
  - Read: go to FINISH.
  - Claim with mem_dout==EMPTY: go to CLAIM_WR with mem_we=1 and mem_din=wdata.
  - Claim with mem_dout!=EMPTY: go to FINISH with claim_ok=0.
- CLAIM_WR: go to FINISH with claim_ok=1.
- FINISH: done[w]=1 for one cycle, then IDLE. err/claim_ok are meaningful only with done.
- Latency from gnt to done (counted in cycles): write 2, read 3, failed claim 3, successful claim 4, illegal 1.
- Only one request is in flight at a time. req is sampled only in IDLE.
- Requesters hold op/addr/wdata stable while req is high. They must drop req by the cycle done is seen; a req still high in IDLE is a new request.
- Simultaneous requests are resolved by RR order; losers keep req high and wait.
- With all NREQ engines requesting continuously, each is granted exactly once per NREQ grants.
- Address checks compare signed values against 0 and GRID_CELLS.

Decomposition:
- Package grid_arb_pkg: opcode constants OP_READ/OP_WRITE/OP_CLAIM, state encoding, EMPTY, GRID_CELLS.
- Sub-module rr_arbiter: NREQ req plus pointer in, one-hot winner plus valid out (combinational), reused by future shared-memory arbiters.

Test Plan:
- Read: grid cell 7 preloaded 3; engine0 reads 7 -> gnt[0], done[0] 3 cycles later, rdata=3, err=0.
- Write then read back: engine2 writes 11 to cell 12 -> done at +2, mem_we seen once. Then engine2 reads cell 12 -> rdata=11.
- Claim race: engines 0 and 1 both claim empty cell 4, wdata 5 and 9, pointer 0 -> engine0 claim_ok=1, rdata=-1. Then engine1 claim_ok=0, rdata=5; cell 4 stays 5.
- Round-robin: all 4 engines read continuously for 8 grants -> gnt order 0,1,2,3,0,1,2,3.
- Illegal: engine3 accesses address 25, then -1, then op=11 -> done 1 cycle after gnt, err=1, mem_re/mem_we never asserted.
- Reset mid-claim: assert reset=0 while in CLAIM_WR -> mem_we falls asynchronously, no done, busy=0. After release, pointer restarts at 0.

Source files
------------

// File: rtl/grid_arb_pkg.sv
// Shared constants and state encoding for the grid RAM access arbiter.
package grid_arb_pkg;

  localparam logic [1:0] OP_READ    = 2'b00;
  localparam logic [1:0] OP_WRITE   = 2'b01;
  localparam logic [1:0] OP_CLAIM   = 2'b10;
  localparam logic [1:0] OP_ILLEGAL = 2'b11;

  localparam int GRID_CELLS = 25;
  localparam int EMPTY      = -1;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ACCESS   = 3'd1,
    ST_CAPTURE  = 3'd2,
    ST_CLAIM_WR = 3'd3,
    ST_FINISH   = 3'd4
  } arb_state_e;

endpackage

// File: rtl/grid_access_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic            valid
);

  logic [PW-1:0] idx;

  always_comb begin
    gnt   = '0;
    valid = 1'b0;
    idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = PW'((int'(ptr) + i) % NREQ);
      if (!valid && req[idx]) begin
        gnt[idx] = 1'b1;
        valid    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/grid_access_arbiter.sv
// Serialises read / write / atomic-claim traffic from NREQ placement engines
// onto the single-port grid RAM, one request in flight at a time.
//
// state    | meaning
// IDLE     | waiting for requests; arbitrates and issues the first RAM cycle
// ACCESS   | RAM cycle in progress (write lands here, read data arrives next)
// CAPTURE  | register RAM read data; decide claim outcome
// CLAIM_WR | cell was EMPTY, claim data being written
// FINISH   | pulse done for the owning engine on the way back to IDLE
module grid_access_arbiter #(
  parameter int                NREQ       = 4,
  parameter int                ADDR_W     = 32,
  parameter int                DATA_W     = 32,
  parameter int                GRID_CELLS = grid_arb_pkg::GRID_CELLS,
  parameter logic [DATA_W-1:0] EMPTY      = DATA_W'(grid_arb_pkg::EMPTY)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req,
  input  logic [2*NREQ-1:0]        op,
  input  logic [NREQ*ADDR_W-1:0]   addr,
  input  logic [NREQ*DATA_W-1:0]   wdata,
  output logic [NREQ-1:0]          gnt,
  output logic [NREQ-1:0]          done,
  output logic [DATA_W-1:0]        rdata,
  output logic                     claim_ok,
  output logic                     err,
  output logic                     busy,
  output logic                     mem_re,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_din,
  input  logic [DATA_W-1:0]        mem_dout
);
  import grid_arb_pkg::*;

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic signed [ADDR_W-1:0] CELLS_S = ADDR_W'(GRID_CELLS);

  arb_state_e          state_q, state_d;
  logic [PW-1:0]       ptr_q, ptr_d;
  logic [PW-1:0]       widx_q, widx_d;
  logic [1:0]          op_q, op_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [NREQ-1:0]     gnt_q, gnt_d, done_q, done_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                claim_ok_q, claim_ok_d, err_q, err_d, busy_q, busy_d;
  logic                mem_re_q, mem_re_d, mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_din_q, mem_din_d;

  logic [NREQ-1:0]     arb_gnt;
  logic                arb_valid;
  logic [PW-1:0]       win_idx;
  logic [1:0]          sel_op;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic                sel_bad;

  rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_rr (
    .req   (req),
    .ptr   (ptr_q),
    .gnt   (arb_gnt),
    .valid (arb_valid)
  );

  always_comb begin
    win_idx   = '0;
    sel_op    = '0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_gnt[i]) begin
        win_idx   = PW'(i);
        sel_op    = op[2*i +: 2];
        sel_addr  = addr[ADDR_W*i +: ADDR_W];
        sel_wdata = wdata[DATA_W*i +: DATA_W];
      end
    end
    // Addresses are signed: negative and >= GRID_CELLS are both out of the grid.
    sel_bad = (sel_op == OP_ILLEGAL) || ($signed(sel_addr) < 0) ||
              ($signed(sel_addr) >= CELLS_S);
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    widx_d     = widx_q;
    op_d       = op_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    claim_ok_d = claim_ok_q;
    err_d      = err_q;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    gnt_d      = '0;
    done_d     = '0;
    mem_re_d   = 1'b0;
    mem_we_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          gnt_d      = arb_gnt;
          widx_d     = win_idx;
          ptr_d      = (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + PW'(1);
          op_d       = sel_op;
          wdata_d    = sel_wdata;
          claim_ok_d = 1'b0;
          err_d      = sel_bad;
          if (sel_bad) begin
            state_d = ST_FINISH;
          end else begin
            state_d    = ST_ACCESS;
            mem_addr_d = sel_addr;
            if (sel_op == OP_WRITE) begin
              mem_we_d  = 1'b1;
              mem_din_d = sel_wdata;
            end else begin
              mem_re_d = 1'b1;
            end
          end
        end
      end
      ST_ACCESS: state_d = (op_q == OP_WRITE) ? ST_FINISH : ST_CAPTURE;
      ST_CAPTURE: begin
        rdata_d = mem_dout;
        if (op_q == OP_CLAIM && mem_dout == EMPTY) begin
          state_d   = ST_CLAIM_WR;
          mem_we_d  = 1'b1;
          mem_din_d = wdata_q;
        end else begin
          state_d = ST_FINISH;
        end
      end
      ST_CLAIM_WR: begin
        claim_ok_d = 1'b1;
        state_d    = ST_FINISH;
      end
      ST_FINISH: begin
        done_d  = NREQ'(1) << widx_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      widx_q     <= '0;
      op_q       <= '0;
      wdata_q    <= '0;
      gnt_q      <= '0;
      done_q     <= '0;
      rdata_q    <= '0;
      claim_ok_q <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      mem_re_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      widx_q     <= widx_d;
      op_q       <= op_d;
      wdata_q    <= wdata_d;
      gnt_q      <= gnt_d;
      done_q     <= done_d;
      rdata_q    <= rdata_d;
      claim_ok_q <= claim_ok_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      mem_re_q   <= mem_re_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
    end
  end

  assign gnt      = gnt_q;
  assign done     = done_q;
  assign rdata    = rdata_q;
  assign claim_ok = claim_ok_q;
  assign err      = err_q;
  assign busy     = busy_q;
  assign mem_re   = mem_re_q;
  assign mem_we   = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_din  = mem_din_q;

endmodule

// File: tb/tb_grid_access_arbiter.sv
// Bench for grid_access_arbiter: grid RAM model, directed scenarios and a
// randomized multi-engine phase checked against a transaction-level model.
module tb_grid_access_arbiter;
  import grid_arb_pkg::*;

  localparam int N = 4, AW = 32, DW = 32, CELLS = 25;
  localparam logic [31:0] EMPTY_V = 32'hFFFF_FFFF;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      req;
  logic [2*N-1:0]    op;
  logic [N*AW-1:0]   addr;
  logic [N*DW-1:0]   wdata;
  logic [N-1:0]      gnt, done;
  logic [DW-1:0]     rdata;
  logic              claim_ok, err, busy, mem_re, mem_we;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_din;
  logic [DW-1:0]     mem_dout = '0;

  grid_access_arbiter dut (
    .clk(clk), .reset(reset), .req(req), .op(op), .addr(addr), .wdata(wdata),
    .gnt(gnt), .done(done), .rdata(rdata), .claim_ok(claim_ok), .err(err),
    .busy(busy), .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  // Grid RAM: one-cycle registered read, plus bench-side clear/preload.
  logic [DW-1:0] ram [CELLS];
  logic          ram_clear = 1'b0, pre_we = 1'b0;
  int            pre_addr = 0;
  logic [31:0]   pre_data = '0;
  int            we_cnt = 0, re_cnt = 0, bad_acc = 0;

  always @(posedge clk) begin
    if (ram_clear) begin
      for (int i = 0; i < CELLS; i++) ram[i] <= EMPTY_V;
    end else if (pre_we) begin
      ram[pre_addr] <= pre_data;
    end
    if (mem_we) begin
      we_cnt <= we_cnt + 1;
      if (mem_addr < CELLS) ram[mem_addr] <= mem_din;
      else bad_acc <= bad_acc + 1;
    end
    if (mem_re) begin
      re_cnt <= re_cnt + 1;
      if (mem_addr < CELLS) mem_dout <= ram[mem_addr];
      else bad_acc <= bad_acc + 1;
    end
  end

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Transaction-level model: grid contents, RR pointer, last read value.
  logic [31:0] shadow [CELLS];
  int          mptr;
  logic [31:0] exp_rdata;
  int          gnt_log [$];

  logic [1:0]  e_op   [N];
  logic [31:0] e_addr [N];
  logic [31:0] e_wd   [N];
  int          e_left [N];
  bit          e_rand [N];

  task automatic set_eng(input int e, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] d, input int n);
    e_op[e] = o; e_addr[e] = a; e_wd[e] = d; e_left[e] = n; e_rand[e] = 1'b0;
  endtask

  task automatic clear_engs();
    for (int e = 0; e < N; e++) begin
      e_left[e] = 0; e_rand[e] = 1'b0;
    end
    gnt_log.delete();
  endtask

  task automatic drive_eng(input int e);
    op[2*e +: 2]     = e_op[e];
    addr[AW*e +: AW] = e_addr[e];
    wdata[DW*e +: DW] = e_wd[e];
    req[e]           = 1'b1;
  endtask

  task automatic gen_rand(input int e);
    int r;
    r = int'($urandom_range(0, 19));
    e_op[e] = (r == 0) ? 2'b11 : 2'($urandom_range(0, 2));
    r = int'($urandom_range(0, 19));
    e_addr[e] = (r == 0) ? 32'hFFFF_FFFF :
                (r == 1) ? 32'(25 + $urandom_range(0, 5)) : 32'($urandom_range(0, 7));
    e_wd[e] = 32'($urandom_range(0, 1000));
  endtask

  task automatic clear_grid();
    @(negedge clk); ram_clear = 1'b1;
    @(negedge clk); ram_clear = 1'b0;
    for (int i = 0; i < CELLS; i++) shadow[i] = EMPTY_V;
  endtask

  task automatic preload(input int a, input logic [31:0] d);
    @(negedge clk); pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk); pre_we = 1'b0;
    shadow[a] = d;
  endtask

  // Drives all engines with pending work; each drops req on done and re-raises
  // one cycle later while it still has transactions left.
  task automatic run_batch(input int budget);
    int inflight, gcyc, exp_lat, w, a;
    logic [31:0] exp_rd;
    logic exp_ok, exp_err, illegal;
    logic [1:0] inf_op;
    bit rearm [N];
    bit finished;
    inflight = -1; finished = 1'b0; gcyc = 0; exp_lat = 0; exp_rd = '0;
    exp_ok = 1'b0; exp_err = 1'b0; inf_op = '0;
    for (int e = 0; e < N; e++) begin
      rearm[e] = 1'b0;
      if (e_left[e] > 0) drive_eng(e);
    end
    for (int c = 0; c < budget && !finished; c++) begin
      @(negedge clk);
      if (gnt !== '0) begin
        w = -1;
        for (int i = 0; i < N; i++) begin
          if (w < 0 && req[(mptr + i) % N]) w = (mptr + i) % N;
        end
        a = 0;
        for (int i = N - 1; i >= 0; i--) if (gnt[i]) a = i;
        chk("gnt_winner", 32'(gnt), (w >= 0) ? 32'(1 << w) : 32'(0));
        chk("gnt_only_in_idle", 32'(inflight == -1), 32'(1));
        chk("busy_after_gnt", 32'(busy), 32'(1));
        if (w < 0) w = a;
        gnt_log.push_back(a);
        mptr = (w + 1) % N; inflight = w; gcyc = c; inf_op = e_op[w];
        illegal = (e_op[w] == 2'b11) || ($signed(e_addr[w]) < 0) ||
                  ($signed(e_addr[w]) >= CELLS);
        exp_err = illegal; exp_ok = 1'b0;
        if (illegal) begin
          exp_lat = 1;
        end else if (e_op[w] == OP_WRITE) begin
          exp_lat = 2; shadow[e_addr[w]] = e_wd[w];
        end else if (e_op[w] == OP_READ) begin
          exp_lat = 3; exp_rdata = shadow[e_addr[w]];
        end else begin
          exp_rdata = shadow[e_addr[w]];
          if (shadow[e_addr[w]] == EMPTY_V) begin
            exp_lat = 4; exp_ok = 1'b1; shadow[e_addr[w]] = e_wd[w];
          end else begin
            exp_lat = 3;
          end
        end
        exp_rd = exp_rdata;
      end
      for (int e = 0; e < N; e++) begin
        if (rearm[e]) begin
          rearm[e] = 1'b0;
          if (e_rand[e]) gen_rand(e);
          drive_eng(e);
        end
      end
      if (done !== '0) begin
        chk("done_onehot", 32'(done), (inflight >= 0) ? 32'(1 << inflight) : 32'(0));
        if (inflight >= 0) begin
          chk("latency", 32'(c - gcyc), 32'(exp_lat));
          chk("rdata", rdata, exp_rd);
          chk("err", 32'(err), 32'(exp_err));
          if (inf_op == OP_CLAIM && !exp_err) chk("claim_ok", 32'(claim_ok), 32'(exp_ok));
          chk("busy_at_done", 32'(busy), 32'(0));
          req[inflight] = 1'b0;
          e_left[inflight]--;
          if (e_left[inflight] > 0) rearm[inflight] = 1'b1;
        end
        inflight = -1;
      end
      finished = (inflight < 0);
      for (int e = 0; e < N; e++) if (e_left[e] > 0) finished = 1'b0;
    end
    if (!finished) chk("batch_timeout", 32'(0), 32'(1));
  endtask

  int w0, r0;
  bit got;

  initial begin
    reset = 1'b0; req = '0; op = '0; addr = '0; wdata = '0;
    ram_clear = 1'b1;
    clear_engs();
    for (int i = 0; i < CELLS; i++) shadow[i] = EMPTY_V;
    mptr = 0; exp_rdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_rdata", rdata, 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_mem_we_re", {30'd0, mem_we, mem_re}, 32'(0));
    chk("rst_err_claim", {30'd0, err, claim_ok}, 32'(0));
    ram_clear = 1'b0;
    @(negedge clk); reset = 1'b1;

    // Two engines race to claim the same empty cell.
    clear_engs();
    set_eng(0, OP_CLAIM, 32'd4, 32'd5, 1);
    set_eng(1, OP_CLAIM, 32'd4, 32'd9, 1);
    run_batch(60);
    chk("race_grants", 32'(gnt_log.size()), 32'(2));
    if (gnt_log.size() == 2) begin
      chk("race_first", 32'(gnt_log[0]), 32'(0));
      chk("race_second", 32'(gnt_log[1]), 32'(1));
    end
    chk("race_cell4", ram[4], 32'd5);

    preload(7, 32'd3);
    clear_engs();
    set_eng(0, OP_READ, 32'd7, 32'd0, 1);
    run_batch(30);
    chk("read7_rdata", rdata, 32'd3);

    clear_engs();
    w0 = we_cnt;
    set_eng(2, OP_WRITE, 32'd12, 32'd11, 1);
    run_batch(30);
    chk("write_we_once", 32'(we_cnt - w0), 32'(1));
    clear_engs();
    set_eng(2, OP_READ, 32'd12, 32'd0, 1);
    run_batch(30);
    chk("readback12", rdata, 32'd11);

    w0 = we_cnt; r0 = re_cnt;
    clear_engs(); set_eng(3, OP_READ, 32'd25, 32'd0, 1); run_batch(30);
    clear_engs(); set_eng(3, OP_WRITE, 32'hFFFF_FFFF, 32'd1, 1); run_batch(30);
    clear_engs(); set_eng(3, 2'b11, 32'd3, 32'd1, 1); run_batch(30);
    chk("illegal_no_mem", 32'((we_cnt - w0) + (re_cnt - r0)), 32'(0));

    clear_engs();
    for (int e = 0; e < N; e++) set_eng(e, OP_READ, 32'(e), 32'd0, 2);
    run_batch(200);
    chk("rr_grants", 32'(gnt_log.size()), 32'(8));
    if (gnt_log.size() == 8) begin
      for (int k = 0; k < 8; k++) chk("rr_order", 32'(gnt_log[k]), 32'(k % 4));
    end

    clear_grid();
    clear_engs();
    for (int e = 0; e < N; e++) begin
      e_rand[e] = 1'b1; e_left[e] = 10; gen_rand(e);
    end
    run_batch(4000);

    // Reset while the claim write is on the RAM port.
    clear_grid();
    clear_engs();
    set_eng(0, OP_CLAIM, 32'd10, 32'd77, 1);
    drive_eng(0);
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (gnt[0]) got = 1'b1;
    end
    chk("rst_test_gnt", 32'(got), 32'(1));
    repeat (2) @(negedge clk);
    chk("claim_wr_we", 32'(mem_we), 32'(1));
    reset = 1'b0; req = '0;
    #1;
    chk("async_we_drop", 32'(mem_we), 32'(0));
    chk("async_re_drop", 32'(mem_re), 32'(0));
    chk("async_busy", 32'(busy), 32'(0));
    @(negedge clk);
    chk("no_done_in_reset", 32'(done), 32'(0));
    chk("cell10_untouched", ram[10], EMPTY_V);
    reset = 1'b1; mptr = 0; exp_rdata = '0;
    clear_engs();
    set_eng(0, OP_READ, 32'd10, 32'd0, 1);
    set_eng(3, OP_READ, 32'd10, 32'd0, 1);
    run_batch(60);
    if (gnt_log.size() > 0) chk("ptr_restart", 32'(gnt_log[0]), 32'(0));
    else chk("ptr_restart_grants", 32'(0), 32'(1));

    chk("bad_mem_addr", 32'(bad_acc), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
